// File: rtl/fifo_seq_pkg.sv
// fifo_seq_pkg
//   Shared types and sizing helpers for the FIFO tile sequencer slice.
//   Contents:
//     seq_state_e     sequencer FSM states (IDLE, CLEAR, STREAM, FIN)
//     DEF_FIFO_DEPTH  default depth of the controlled FIFO bank
//     OCC_W           occupancy counter width for the default depth
//     occ_bits()      occupancy counter width for an arbitrary depth
package fifo_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    STREAM,
    FIN
  } seq_state_e;

  localparam int DEF_FIFO_DEPTH = 4;
  localparam int OCC_W          = $clog2(DEF_FIFO_DEPTH + 1);

  // Width able to hold every value 0..depth inclusive.
  function automatic int occ_bits(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fifo_occ_counter.sv
// fifo_occ_counter
//   Up/down occupancy tracker for the controlled FIFO. It is the sequencer's
//   own zero-lag view of how many columns sit in the FIFO, since the FIFO's
//   registered full/empty flags trail by one cycle.
//   Ports:
//     clk    in   clock
//     rst    in   synchronous active-high reset
//     clear  in   synchronous clear, mirrors the FIFO clear strobe
//     inc    in   one column written this cycle
//     dec    in   one column read this cycle
//     full   out  occupancy equals DEPTH
//     empty  out  occupancy equals zero
module fifo_occ_counter
  import fifo_seq_pkg::*;
#(
  parameter int DEPTH = DEF_FIFO_DEPTH,
  parameter int W     = OCC_W
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic inc,
  input  logic dec,
  output logic full,
  output logic empty
);

  logic [W-1:0] occ;

  // Occupancy register; clear wins over any same-cycle strobe.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      occ <= '0;
    end else if (inc && !dec) begin
      occ <= occ + W'(1);
    end else if (dec && !inc) begin
      occ <= occ - W'(1);
    end
  end

  assign full  = (occ == W'(DEPTH));
  assign empty = (occ == '0);

  // The arbitration upstream must never push past full or pop below empty.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(inc && !dec && !clear && full));
  a_no_underflow: assert property (@(posedge clk) disable iff (rst)
    !(dec && !inc && !clear && empty));

endmodule

// File: rtl/fifo_tile_sequencer.sv
// fifo_tile_sequencer
//   Sequences one DualAccess FIFO bank between the input pixel stream and the
//   PE array. Each tile clears the FIFO, admits cfg_cols columns under
//   ready/valid and pops them toward the PEs, reads taking priority over
//   writes. Columns at index KERNEL-1 and above are flagged window-valid.
//   Optional macro: FIFO_SEQ_PERF_EN adds stall performance counters.
//   Ports:
//     clk, rst             clock, synchronous active-high reset
//     start                launch a job (sampled only in IDLE)
//     cfg_cols, cfg_tiles  job shape, latched on accepted start
//     in_valid / in_ready  upstream column handshake
//     pe_ready             PE array can take a column next cycle
//     fifo_wr_en/rd_en     FIFO write / read strobes
//     fifo_clear           FIFO synchronous clear
//     out_valid            FIFO data_out holds a fresh column
//     win_valid            out_valid with col_idx >= KERNEL-1
//     col_idx, tile_idx    position of the current column / tile
//     busy, done           job active / one-cycle job-end pulse
//     perf_in_stall        (FIFO_SEQ_PERF_EN) upstream stall cycles in STREAM
//     perf_pe_stall        (FIFO_SEQ_PERF_EN) cycles data waited on the PEs
module fifo_tile_sequencer
  import fifo_seq_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int KERNEL     = 3,
  parameter int COL_W      = 8,
  parameter int TILE_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [COL_W-1:0]  cfg_cols,
  input  logic [TILE_W-1:0] cfg_tiles,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              pe_ready,
  output logic              fifo_wr_en,
  output logic              fifo_rd_en,
  output logic              fifo_clear,
  output logic              out_valid,
  output logic              win_valid,
  output logic [COL_W-1:0]  col_idx,
  output logic [TILE_W-1:0] tile_idx,
  output logic              busy,
  output logic              done
`ifdef FIFO_SEQ_PERF_EN
  ,
  output logic [31:0]       perf_in_stall,
  output logic [31:0]       perf_pe_stall
`endif
);

  seq_state_e        state, state_next;
  logic [COL_W-1:0]  cols_q;
  logic [TILE_W-1:0] tiles_q;
  logic [COL_W-1:0]  wr_cnt;
  logic [COL_W-1:0]  rd_cnt;
  logic              occ_full;
  logic              occ_empty;
  logic              last_tile;
  logic              start_ok;

  fifo_occ_counter #(
    .DEPTH (FIFO_DEPTH),
    .W     (occ_bits(FIFO_DEPTH))
  ) u_occ (
    .clk   (clk),
    .rst   (rst),
    .clear (fifo_clear),
    .inc   (fifo_wr_en),
    .dec   (fifo_rd_en),
    .full  (occ_full),
    .empty (occ_empty)
  );

  assign start_ok  = (state == IDLE) && start;
  assign last_tile = (tile_idx == (tiles_q - TILE_W'(1)));
  assign busy      = (state != IDLE);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and strobes. A read is chosen first, and only when no read
  // happens may a write be admitted, so the two strobes stay exclusive.
  // A tile ends once every column has been read back out.
  always_comb begin
    state_next = state;
    fifo_clear = 1'b0;
    in_ready   = 1'b0;
    fifo_rd_en = 1'b0;
    fifo_wr_en = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = ((cfg_cols == '0) || (cfg_tiles == '0)) ? FIN : CLEAR;
        end
      end
      CLEAR: begin
        fifo_clear = 1'b1;
        state_next = STREAM;
      end
      STREAM: begin
        fifo_rd_en = !occ_empty && pe_ready && (rd_cnt < cols_q);
        in_ready   = !fifo_rd_en && !occ_full && (wr_cnt < cols_q);
        fifo_wr_en = in_valid && in_ready;
        if (rd_cnt == cols_q) begin
          state_next = last_tile ? FIN : CLEAR;
        end
      end
      FIN: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Job configuration, per-tile column counters and the output-side flags.
  // out_valid/win_valid/col_idx trail the read strobe by one cycle to line
  // up with the FIFO's registered data_out.
  always_ff @(posedge clk) begin
    if (rst) begin
      cols_q    <= '0;
      tiles_q   <= '0;
      wr_cnt    <= '0;
      rd_cnt    <= '0;
      col_idx   <= '0;
      tile_idx  <= '0;
      out_valid <= 1'b0;
      win_valid <= 1'b0;
    end else begin
      out_valid <= fifo_rd_en;
      win_valid <= fifo_rd_en && (rd_cnt >= COL_W'(KERNEL - 1));
      if (fifo_rd_en) begin
        col_idx <= rd_cnt;
      end
      case (state)
        IDLE: begin
          if (start) begin
            cols_q   <= cfg_cols;
            tiles_q  <= cfg_tiles;
            tile_idx <= '0;
            col_idx  <= '0;
          end
        end
        CLEAR: begin
          wr_cnt  <= '0;
          rd_cnt  <= '0;
          col_idx <= '0;
        end
        STREAM: begin
          if (fifo_wr_en) begin
            wr_cnt <= wr_cnt + COL_W'(1);
          end
          if (fifo_rd_en) begin
            rd_cnt <= rd_cnt + COL_W'(1);
          end
          if ((rd_cnt == cols_q) && !last_tile) begin
            tile_idx <= tile_idx + TILE_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef FIFO_SEQ_PERF_EN
  logic in_stall;
  logic pe_stall;

  assign in_stall = (state == STREAM) && in_valid && !in_ready;
  assign pe_stall = (state == STREAM) && !occ_empty && !pe_ready && (rd_cnt < cols_q);

  // Saturating stall counters, zeroed at the start of every job.
  always_ff @(posedge clk) begin
    if (rst || start_ok) begin
      perf_in_stall <= '0;
      perf_pe_stall <= '0;
    end else begin
      if (in_stall && (perf_in_stall != '1)) begin
        perf_in_stall <= perf_in_stall + 32'd1;
      end
      if (pe_stall && (perf_pe_stall != '1)) begin
        perf_pe_stall <= perf_pe_stall + 32'd1;
      end
    end
  end
`else
  logic unused_start_ok;
  assign unused_start_ok = start_ok;
`endif

endmodule

// File: tb/tb_fifo_tile_sequencer.sv
// tb_fifo_tile_sequencer
//   Self-checking bench for fifo_tile_sequencer. Expected output columns are
//   queued when a job is launched and consumed as out_valid appears. A bench
//   occupancy tracker follows the FIFO strobes to catch writes into a full
//   FIFO, reads from an empty one, and in_ready held high while full.
module tb_fifo_tile_sequencer;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] cfg_cols;
  logic [7:0] cfg_tiles;
  logic       in_valid;
  logic       in_ready;
  logic       pe_ready;
  logic       fifo_wr_en;
  logic       fifo_rd_en;
  logic       fifo_clear;
  logic       out_valid;
  logic       win_valid;
  logic [7:0] col_idx;
  logic [7:0] tile_idx;
  logic       busy;
  logic       done;
`ifdef FIFO_SEQ_PERF_EN
  logic [31:0] perf_in_stall;
  logic [31:0] perf_pe_stall;
`endif

  always #5 clk = ~clk;

  fifo_tile_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .cfg_cols   (cfg_cols),
    .cfg_tiles  (cfg_tiles),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .pe_ready   (pe_ready),
    .fifo_wr_en (fifo_wr_en),
    .fifo_rd_en (fifo_rd_en),
    .fifo_clear (fifo_clear),
    .out_valid  (out_valid),
    .win_valid  (win_valid),
    .col_idx    (col_idx),
    .tile_idx   (tile_idx),
    .busy       (busy),
    .done       (done)
`ifdef FIFO_SEQ_PERF_EN
    ,
    .perf_in_stall (perf_in_stall),
    .perf_pe_stall (perf_pe_stall)
`endif
  );

  typedef struct {
    int tile;
    int col;
    bit win;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  int tests_run = 0;
  int fail_cnt  = 0;
  int cyc       = 0;
  int occ_m     = 0;
  int wr_cnt_m, rd_cnt_m, clr_cnt_m, out_cnt_m, win_cnt_m, done_cnt_m;
  int last_out_cyc, done_cyc;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      fail_cnt++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic resetCounters();
    wr_cnt_m     = 0;
    rd_cnt_m     = 0;
    clr_cnt_m    = 0;
    out_cnt_m    = 0;
    win_cnt_m    = 0;
    done_cnt_m   = 0;
    last_out_cyc = -100;
    done_cyc     = -1;
  endtask

  // Launch a job with a one-cycle start pulse and queue its expected columns.
  task automatic applyStimulus(input int cols, input int tiles);
    cfg_cols  = 8'(cols);
    cfg_tiles = 8'(tiles);
    resetCounters();
    if (cols > 0 && tiles > 0) begin
      for (int t = 0; t < tiles; t++) begin
        for (int c = 0; c < cols; c++) begin
          sb.push_back('{tile: t, col: c, win: (c >= 2)});
        end
      end
    end
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic waitDone(input int budget);
    int n;
    n = 0;
    while (done_cnt_m == 0 && n < budget) begin
      tick();
      n++;
    end
    if (done_cnt_m == 0) checkOutput("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic checkIdle(input string pfx);
    checkOutput({pfx, "_busy"}, 32'(busy), 32'd0);
    checkOutput({pfx, "_done"}, 32'(done), 32'd0);
    checkOutput({pfx, "_in_ready"}, 32'(in_ready), 32'd0);
    checkOutput({pfx, "_strobes"}, {29'd0, fifo_wr_en, fifo_rd_en, fifo_clear}, 32'd0);
    checkOutput({pfx, "_out_valid"}, 32'(out_valid), 32'd0);
    checkOutput({pfx, "_win_valid"}, 32'(win_valid), 32'd0);
    checkOutput({pfx, "_col_idx"}, 32'(col_idx), 32'd0);
    checkOutput({pfx, "_tile_idx"}, 32'(tile_idx), 32'd0);
  endtask

  // Mid-cycle monitor: occupancy tracking, scoreboard pops, done bookkeeping.
  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      if (fifo_wr_en && fifo_rd_en) checkOutput("wr_rd_same_cycle", 32'd1, 32'd0);
      if (occ_m == DEPTH) checkOutput("in_ready_when_full", 32'(in_ready), 32'd0);
      if (fifo_clear) begin
        clr_cnt_m++;
        occ_m = 0;
      end
      if (fifo_wr_en) begin
        if (occ_m >= DEPTH) checkOutput("wr_into_full", 32'd1, 32'd0);
        occ_m++;
        wr_cnt_m++;
      end
      if (fifo_rd_en) begin
        if (occ_m == 0) checkOutput("rd_from_empty", 32'd1, 32'd0);
        occ_m--;
        rd_cnt_m++;
      end
      if (out_valid) begin
        out_cnt_m++;
        last_out_cyc = cyc;
        if (sb.size() == 0) begin
          checkOutput("unexpected_out_valid", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          checkOutput("col_idx", 32'(col_idx), 32'(e.col));
          checkOutput("win_valid", 32'(win_valid), 32'(e.win));
          checkOutput("tile_idx", 32'(tile_idx), 32'(e.tile));
        end
      end else if (win_valid) begin
        checkOutput("win_without_out", 32'd1, 32'd0);
      end
      if (win_valid) win_cnt_m++;
      if (done) begin
        done_cnt_m++;
        done_cyc = cyc;
      end
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    cfg_cols  = '0;
    cfg_tiles = '0;
    in_valid  = 1'b0;
    pe_ready  = 1'b0;
    resetCounters();
    repeat (3) tick();
    checkIdle("reset");
    rst = 1'b0;
    tick();

    // 1: streaming with both sides always ready
    in_valid = 1'b1;
    pe_ready = 1'b1;
    applyStimulus(5, 1);
    waitDone(100);
    tick();
    checkOutput("t1_writes", 32'(wr_cnt_m), 32'd5);
    checkOutput("t1_reads", 32'(rd_cnt_m), 32'd5);
    checkOutput("t1_out_count", 32'(out_cnt_m), 32'd5);
    checkOutput("t1_win_count", 32'(win_cnt_m), 32'd3);
    checkOutput("t1_done_count", 32'(done_cnt_m), 32'd1);
    checkOutput("t1_done_after_last_out", 32'(done_cyc), 32'(last_out_cyc + 1));
    checkOutput("t1_sb_empty", 32'(sb.size()), 32'd0);
    checkOutput("t1_busy_after", 32'(busy), 32'd0);

    // 2: PE array stalled until the FIFO fills
    in_valid = 1'b1;
    pe_ready = 1'b0;
    applyStimulus(6, 1);
    repeat (10) tick();
    checkOutput("t2_writes_at_full", 32'(wr_cnt_m), 32'd4);
    checkOutput("t2_in_ready_full", 32'(in_ready), 32'd0);
    checkOutput("t2_no_reads", 32'(rd_cnt_m), 32'd0);
    pe_ready = 1'b1;
    waitDone(100);
    tick();
    checkOutput("t2_writes", 32'(wr_cnt_m), 32'd6);
    checkOutput("t2_out_count", 32'(out_cnt_m), 32'd6);
    checkOutput("t2_sb_empty", 32'(sb.size()), 32'd0);

    // 3: multi-tile job
    applyStimulus(3, 3);
    waitDone(200);
    tick();
    checkOutput("t3_clears", 32'(clr_cnt_m), 32'd3);
    checkOutput("t3_out_count", 32'(out_cnt_m), 32'd9);
    checkOutput("t3_done_count", 32'(done_cnt_m), 32'd1);
    checkOutput("t3_sb_empty", 32'(sb.size()), 32'd0);

    // 4: zero-length jobs, then a start while busy
    applyStimulus(0, 2);
    checkOutput("t4a_done", 32'(done), 32'd1);
    tick();
    checkOutput("t4a_done_low", 32'(done), 32'd0);
    checkOutput("t4a_idle", 32'(busy), 32'd0);
    checkOutput("t4a_strobes", 32'(wr_cnt_m + rd_cnt_m + clr_cnt_m), 32'd0);
    applyStimulus(3, 0);
    checkOutput("t4b_done", 32'(done), 32'd1);
    tick();
    checkOutput("t4b_strobes", 32'(wr_cnt_m + rd_cnt_m + clr_cnt_m), 32'd0);
    applyStimulus(4, 1);
    tick();
    tick();
    cfg_cols  = 8'd2;
    cfg_tiles = 8'd5;
    start     = 1'b1;
    tick();
    start = 1'b0;
    waitDone(100);
    repeat (5) tick();
    checkOutput("t4c_out_count", 32'(out_cnt_m), 32'd4);
    checkOutput("t4c_clears", 32'(clr_cnt_m), 32'd1);
    checkOutput("t4c_done_count", 32'(done_cnt_m), 32'd1);
    checkOutput("t4c_idle", 32'(busy), 32'd0);

    // 5: reset in the middle of a tile
    in_valid = 1'b1;
    pe_ready = 1'b0;
    applyStimulus(6, 1);
    for (int n = 0; n < 50 && wr_cnt_m < 2; n++) tick();
    in_valid = 1'b0;
    checkOutput("t5_occ_before_reset", 32'(occ_m), 32'd2);
    rst = 1'b1;
    tick();
    checkIdle("t5_after_reset");
    sb.delete();
    occ_m = 0;
    rst   = 1'b0;
    repeat (3) tick();
    checkOutput("t5_no_done", 32'(done_cnt_m), 32'd0);
    in_valid = 1'b1;
    pe_ready = 1'b1;
    applyStimulus(5, 1);
    waitDone(100);
    tick();
    checkOutput("t5_rerun_out", 32'(out_cnt_m), 32'd5);
    checkOutput("t5_rerun_win", 32'(win_cnt_m), 32'd3);
    checkOutput("t5_rerun_sb_empty", 32'(sb.size()), 32'd0);

`ifdef FIFO_SEQ_PERF_EN
    // 6: PE stall counter
    in_valid = 1'b1;
    pe_ready = 1'b0;
    applyStimulus(4, 1);
    for (int n = 0; n < 20 && wr_cnt_m < 1; n++) tick();
    repeat (4) tick();
    pe_ready = 1'b1;
    checkOutput("t6_pe_stall", perf_pe_stall, 32'd4);
    waitDone(100);
    tick();
    checkOutput("t6_pe_stall_final", perf_pe_stall, 32'd4);
    applyStimulus(0, 1);
    checkOutput("t6_pe_stall_cleared", perf_pe_stall, 32'd0);
    checkOutput("t6_in_stall_cleared", perf_in_stall, 32'd0);
    tick();
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
    $finish;
  end

endmodule
